// File: rtl/ctrl_seq_pkg.sv
// Shared types and helpers for the ctrl_sequencer block.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Cycles without a wrap before RUN gives up: one full counter period plus one.
  function automatic int unsigned timeout_f(input int unsigned width);
    return (32'd1 << width) + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_seq_downcnt.sv
// Loadable down-counter that saturates at zero, with a zero flag.
module ctrl_seq_downcnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Command-driven controller: runs the counter for N wraps, holds H idle cycles,
// then pulses done with a snapshot of count taken when ctrl dropped.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LOOPW = 8,
  parameter int unsigned HOLDW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LOOPW-1:0] cmd_loops,
  input  logic [HOLDW-1:0] cmd_hold,
  output logic             ctrl,
  input  logic [WIDTH-1:0] count,
  input  logic             loop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_count,
  output logic             err
);

  localparam int unsigned       TMOW    = WIDTH + 2;
  localparam logic [TMOW-1:0]   TIMEOUT = TMOW'(timeout_f(WIDTH));

  state_t             state_q, state_d;
  logic [TMOW-1:0]    tmo_q, tmo_d, tmo_inc;
  logic [WIDTH-1:0]   dc_q, dc_d;
  logic               err_q, err_d;
  logic               ctrl_q, busy_q, done_q;

  logic               load;
  logic               loops_dec, hold_dec;
  logic [LOOPW-1:0]   loops_left;
  logic [HOLDW-1:0]   hold_left;
  logic               loops_zero, hold_zero;

  ctrl_seq_downcnt #(.W(LOOPW)) u_loops (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_val_i (cmd_loops),
    .dec_i      (loops_dec),
    .cnt_o      (loops_left),
    .zero_o     (loops_zero)
  );

  ctrl_seq_downcnt #(.W(HOLDW)) u_hold (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_val_i (cmd_hold),
    .dec_i      (hold_dec),
    .cnt_o      (hold_left),
    .zero_o     (hold_zero)
  );

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    dc_d      = dc_q;
    err_d     = err_q;
    load      = 1'b0;
    loops_dec = 1'b0;
    hold_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = (cmd_loops != '0) ? RUN : HOLD;
        end
      end
      RUN: begin
        // A wrap takes priority over a timeout landing in the same cycle.
        if (loop) begin
          loops_dec = 1'b1;
          tmo_d     = '0;
          if ((loops_left == LOOPW'(1)) || loops_zero) begin
            dc_d    = count;
            state_d = HOLD;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TIMEOUT) begin
            err_d   = 1'b1;
            dc_d    = count;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_zero) begin
          state_d = DONE;
        end else begin
          hold_dec = 1'b1;
          if (hold_left == HOLDW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      dc_q    <= '0;
      err_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      dc_q    <= dc_d;
      err_q   <= err_d;
      ctrl_q  <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign ctrl       = ctrl_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_count = dc_q;
  assign err        = err_q;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Drives the `ctrl` enable input of the wrap-around `counter` and watches its `count`/`loop` outputs. Each command asks for N complete counter wraps followed by a hold of H idle cycles. The block runs the counter for those wraps, stops it, holds, and then reports completion with a snapshot of `count`. It replaces hand-written `ctrl` stimulus sequences with a reusable, command-driven controller in the counter subsystem.

## Interface
- `WIDTH`, 4: counter width; also sets the wrap timeout.
- `LOOPW`, 8: width of the loop-count command field.
- `HOLDW`, 8: width of the hold-cycle command field.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `cmd_valid` in, 1: a command is offered.
- `cmd_ready` out, 1: the block can accept a command.
- `cmd_loops` in, LOOPW: number of wraps to run; 0 means no run phase.
- `cmd_hold` in, HOLDW: number of idle cycles after the run phase.
- `ctrl` out, 1: counter enable, registered.
- `count` in, WIDTH: counter value.
- `loop` in, 1: counter wrap pulse; each cycle it is sampled high counts as one completed wrap.
- `busy` out, 1: a command is in progress.
- `done` out, 1: one-cycle completion pulse.
- `done_count` out, WIDTH: `count` captured when `ctrl` was dropped.
- `err` out, 1: sticky flag, set when a wrap timeout occurs.

## Operation
- States are IDLE, RUN, HOLD and DONE.
- Reset values: state IDLE, `ctrl`=0, `busy`=0, `done`=0, `done_count`=0, `err`=0. `cmd_ready` = (state==IDLE), so it reads 1 after reset.
- IDLE:
  - `cmd_valid && cmd_ready` accepts the command, loads `loops_left`=`cmd_loops` and `hold_left`=`cmd_hold`, and clears `err`.
  - If `cmd_loops`≠0, go to RUN; otherwise go to HOLD.
- RUN:
  - `ctrl`=1.
  - Each sampled `loop` decrements `loops_left` and clears the timeout counter.
  - When `loop` arrives with `loops_left`==1: capture `done_count`←`count`, then go to HOLD.
- Timeout:
  - The timeout counter increments every RUN cycle without `loop`.
  - When it reaches TIMEOUT = 2^WIDTH+1: set `err`, capture `done_count`, go to HOLD.
  - If `loop` arrives in the same cycle the timeout counter reaches TIMEOUT, `loop` wins: no error.
- HOLD:
  - `ctrl`=0.
  - If `hold_left`==0, go to DONE immediately; otherwise decrement each cycle and go to DONE on the cycle `hold_left` reaches 1.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `busy`=1 in RUN, HOLD and DONE.
- `loop` is ignored outside RUN.
- `cmd_valid` outside IDLE is not accepted; the command stays pending and is taken in the first IDLE cycle.
- `rst` asserted in any state: IDLE on the next edge, with all outputs at their reset values.
- Width rules:
  - `loops_left` is LOOPW bits and `hold_left` is HOLDW bits. Neither wraps; both are only decremented when nonzero.
  - The timeout counter is WIDTH+2 bits.

## Timing
- Accept at edge k: `ctrl`=1 from cycle k+1 (RUN).
- Final `loop` sampled at edge m: `ctrl`=0 from cycle m+1, and `done_count` is valid from m+1 onward.
- HOLD occupies max(H,1) cycles. `done` is high in the cycle after HOLD exits.
- `cmd_ready` returns to 1 the cycle after `done`.
- Back-to-back commands: at least one IDLE cycle separates two commands.
- Latency from accept to `done`:
  - with `cmd_loops`=0: 1 + max(H,1) cycles;
  - with a run phase: RUN length + max(H,1) + 1 cycles.

## Structure
- Package `ctrl_seq_pkg`:
  - `state_t` enum (IDLE, RUN, HOLD, DONE);
  - `timeout_f(WIDTH)` function returning 2^WIDTH+1.
- Sub-module `ctrl_seq_downcnt`: a loadable down-counter with a zero flag, parameterised on width. It is instantiated twice, for `loops_left` and `hold_left`.
- The timeout counter and `done_count` capture stay in the top level.

## Test plan
All scenarios use WIDTH=4 with the real `counter` attached.
- **Normal run:** `cmd_loops`=2, `cmd_hold`=3 → `ctrl` high from the cycle after accept until the second `loop`, then low for 3 cycles; `done` pulses once; `done_count` = `count` at the drop; `err`=0.
- **No run phase:** `cmd_loops`=0, `cmd_hold`=0 → `ctrl` never rises; `done` 2 cycles after accept; `cmd_ready`=1 the next cycle.
- **Timeout:** `loop` forced to 0, `cmd_loops`=1, `cmd_hold`=2 → `ctrl` high for 17 cycles, then `err`=1 and HOLD; `err` stays 1 after `done` until the next accept clears it.
- **Command during busy:** `cmd_valid` held high from accept onward → `cmd_ready`=0 while `busy`; the second command is accepted in the cycle after `done`.
- **Reset mid-run:** `rst`=1 for 1 cycle during RUN → `ctrl`=0, `busy`=0, `err`=0 on the next edge; `cmd_ready`=1 afterwards.
- **Stray pulse in IDLE:** `loop` pulsed while IDLE, then `cmd_loops`=1 → the stray pulse is ignored; exactly one wrap is run after accept.
